little_computer: RTL and testbench

LITTLE_COMPUTER -- requirements
Module: little_computer

---
 rtl/little_computer.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_little_computer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/little_computer.sv
// rtl/little_computer.sv - UART program loader writing 16-bit words into SDRAM
// Optional feature macro: LC_AUTO_REFRESH_EN (periodic SDRAM auto-refresh while READY).
module little_computer #(
    parameter int CLK_DIV        = 325,
    parameter int INIT_CYCLES    = 5000,
    parameter int REFRESH_CYCLES = 390
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        debug_mode,
    input  logic        uart_rx_in,
    output logic [12:0] dram_addr,
    output logic [1:0]  dram_ba,
    output logic        dram_ras_n,
    output logic        dram_cas_n,
    output logic        dram_we_n,
    output logic        dram_clk,
    inout  wire  [15:0] dram_dq,
    output logic        sysrst_n,
    output logic [15:0] word_count,
    output logic [7:0]  debug_byte
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        D_INIT_WAIT, D_PRECHARGE, D_INIT_REF, D_INIT_NOP, D_LOAD_MODE, D_READY,
        D_ACTIVE, D_ACT_NOP, D_WRITE, D_WR_NOP, D_REFRESH, D_REF_NOP
    } dram_state_t;

    localparam logic [2:0]  CMD_NOP       = 3'b111;
    localparam logic [2:0]  CMD_ACTIVE    = 3'b011;
    localparam logic [2:0]  CMD_WRITE     = 3'b100;
    localparam logic [2:0]  CMD_PRECHARGE = 3'b010;
    localparam logic [2:0]  CMD_REFRESH   = 3'b001;
    localparam logic [2:0]  CMD_LOAD_MODE = 3'b000;
    // burst length 1, sequential, CAS latency 2
    localparam logic [12:0] MODE_REG      = 13'h0020;

    logic [15:0] div_cnt;
    logic        tick;
    logic        rx_meta, rx_s, rx_prev;
    rx_state_t   rx_state, rx_state_next;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic [7:0]  rx_data;
    logic        data_ready;
    logic        start_seen, bit_sample, byte_good;
    logic        clocked_first_byte;
    logic [7:0]  first_byte;
    logic [15:0] uart_word;
    logic        uart_word_ready;
    logic        pend_valid;
    logic [15:0] pend_data, pend_addr;
    logic [15:0] data_in_r, addr_r;
    dram_state_t d_state, d_state_next;
    logic [15:0] d_cnt;
    logic        init_ref_two;
    logic        ref_req;
    logic        accept;
    logic [2:0]  cmd;

    assign sysrst_n   = ~(rst | load_en);
    assign debug_byte = debug_mode ? rx_data : 8'h00;
    assign dram_clk   = ~clk;
    assign dram_ba    = 2'b00;

    assign tick = (div_cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        start_seen    = 1'b0;
        bit_sample    = 1'b0;
        byte_good     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_next = RX_START;
                    start_seen    = 1'b1;
                end
            end
            RX_START: begin
                if (tick && tick_cnt == 4'd7) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (tick && tick_cnt == 4'd15) begin
                    bit_sample = 1'b1;
                    if (bit_cnt == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && tick_cnt == 4'd15) begin
                    rx_state_next = RX_IDLE;
                    byte_good     = rx_s;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            rx_data    <= '0;
            data_ready <= 1'b0;
        end else begin
            if (rx_state_next != rx_state) tick_cnt <= '0;
            else if (tick)                 tick_cnt <= tick_cnt + 4'd1;
            if (start_seen) begin
                data_ready <= 1'b0;
                bit_cnt    <= '0;
            end
            if (bit_sample) begin
                shift_reg <= {rx_s, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (byte_good) begin
                rx_data    <= shift_reg;
                data_ready <= 1'b1;
            end
        end
    end

    // shift_reg still holds the completed byte in the byte_good cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clocked_first_byte <= 1'b0;
            first_byte         <= '0;
            uart_word          <= '0;
            uart_word_ready    <= 1'b0;
        end else begin
            uart_word_ready <= 1'b0;
            if (byte_good) begin
                if (!load_en) begin
                    clocked_first_byte <= 1'b0;
                end else if (!clocked_first_byte) begin
                    first_byte         <= shift_reg;
                    clocked_first_byte <= 1'b1;
                end else begin
                    uart_word          <= {shift_reg, first_byte};
                    uart_word_ready    <= 1'b1;
                    clocked_first_byte <= 1'b0;
                end
            end
        end
    end

    assign accept = (d_state == D_READY) && (d_state_next == D_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= 16'hFFFF;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_addr  <= '0;
            data_in_r  <= '0;
            addr_r     <= '0;
        end else begin
            if (uart_word_ready) begin
                word_count <= word_count + 16'd1;
                pend_valid <= 1'b1;
                pend_data  <= uart_word;
                pend_addr  <= word_count + 16'd1;
            end else if (accept) begin
                pend_valid <= 1'b0;
            end
            if (accept) begin
                data_in_r <= pend_data;
                addr_r    <= pend_addr;
            end
        end
    end

`ifdef LC_AUTO_REFRESH_EN
    logic [15:0] ref_timer;
    logic        init_done;

    // Free-running interval timer once init completes; the request waits for READY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_timer <= '0;
            ref_req   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            if (d_state == D_READY)   init_done <= 1'b1;
            if (d_state == D_REFRESH) ref_req   <= 1'b0;
            if (init_done) begin
                if (ref_timer == 16'(REFRESH_CYCLES - 1)) begin
                    ref_timer <= '0;
                    ref_req   <= 1'b1;
                end else begin
                    ref_timer <= ref_timer + 16'd1;
                end
            end
        end
    end
`else
    assign ref_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state      <= D_INIT_WAIT;
            d_cnt        <= '0;
            init_ref_two <= 1'b0;
        end else begin
            d_state <= d_state_next;
            if (d_state_next != d_state) d_cnt <= '0;
            else                         d_cnt <= d_cnt + 16'd1;
            if (d_state == D_INIT_NOP && d_state_next == D_INIT_REF) init_ref_two <= 1'b1;
        end
    end

    always_comb begin
        d_state_next = d_state;
        case (d_state)
            D_INIT_WAIT: if (d_cnt == 16'(INIT_CYCLES - 1)) d_state_next = D_PRECHARGE;
            D_PRECHARGE: d_state_next = D_INIT_REF;
            D_INIT_REF:  d_state_next = D_INIT_NOP;
            D_INIT_NOP:  if (d_cnt == 16'd6) d_state_next = init_ref_two ? D_LOAD_MODE : D_INIT_REF;
            D_LOAD_MODE: d_state_next = D_READY;
            D_READY: begin
                if (ref_req)         d_state_next = D_REFRESH;
                else if (pend_valid) d_state_next = D_ACTIVE;
            end
            D_ACTIVE:    d_state_next = D_ACT_NOP;
            D_ACT_NOP:   d_state_next = D_WRITE;
            D_WRITE:     d_state_next = D_WR_NOP;
            D_WR_NOP:    if (d_cnt == 16'd2) d_state_next = D_READY;
            D_REFRESH:   d_state_next = D_REF_NOP;
            D_REF_NOP:   if (d_cnt == 16'd6) d_state_next = D_READY;
            default:     d_state_next = D_INIT_WAIT;
        endcase
    end

    always_comb begin
        cmd       = CMD_NOP;
        dram_addr = '0;
        case (d_state)
            D_PRECHARGE: begin
                cmd       = CMD_PRECHARGE;
                dram_addr = 13'h0400;
            end
            D_INIT_REF, D_REFRESH: cmd = CMD_REFRESH;
            D_LOAD_MODE: begin
                cmd       = CMD_LOAD_MODE;
                dram_addr = MODE_REG;
            end
            D_ACTIVE: begin
                cmd       = CMD_ACTIVE;
                dram_addr = {7'd0, addr_r[15:10]};
            end
            D_WRITE: begin
                cmd       = CMD_WRITE;
                dram_addr = {2'b00, 1'b1, addr_r[9:0]};
            end
            default: ;
        endcase
    end

    assign {dram_ras_n, dram_cas_n, dram_we_n} = cmd;
    assign dram_dq = (d_state == D_WRITE) ? data_in_r : 16'hzzzz;

endmodule

// File: tb/tb_little_computer.sv
// tb/tb_little_computer.sv - scoreboard bench for the UART-to-SDRAM loader
`timescale 1ns/1ps
module tb_little_computer;
    localparam int CLK_DIV        = 4;
    localparam int INIT_CYCLES    = 100;
    localparam int REFRESH_CYCLES = 390;
    localparam int BIT_CLKS       = 16 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b1;
    logic        debug_mode = 1'b0;
    logic        uart_rx_in = 1'b1;
    logic [12:0] dram_addr;
    logic [1:0]  dram_ba;
    logic        dram_ras_n, dram_cas_n, dram_we_n, dram_clk;
    wire  [15:0] dram_dq;
    logic        sysrst_n;
    logic [15:0] word_count;
    logic [7:0]  debug_byte;
    logic [2:0]  cmd;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e_w;
    logic [2:0]  log_cmd[$];
    logic [12:0] log_addr[$];
    int          log_cyc[$];
    logic [5:0]  act_row = '0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_pulses = 0;
    int          ref_cnt = 0;
    int          ref0;

    little_computer #(
        .CLK_DIV(CLK_DIV), .INIT_CYCLES(INIT_CYCLES), .REFRESH_CYCLES(REFRESH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .debug_mode(debug_mode),
        .uart_rx_in(uart_rx_in), .dram_addr(dram_addr), .dram_ba(dram_ba),
        .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n), .dram_we_n(dram_we_n),
        .dram_clk(dram_clk), .dram_dq(dram_dq), .sysrst_n(sysrst_n),
        .word_count(word_count), .debug_byte(debug_byte)
    );

    assign cmd = {dram_ras_n, dram_cas_n, dram_we_n};

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx_in = 1'b0;
        repeat (BIT_CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            repeat (BIT_CLKS) @(posedge clk);
        end
        uart_rx_in = stop_bit;
        repeat (BIT_CLKS) @(posedge clk);
        uart_rx_in = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Monitor: SDRAM command decode and write scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (dut.uart_word_ready) wr_pulses++;
            if (cmd != 3'b111) begin
                log_cmd.push_back(cmd);
                log_addr.push_back(dram_addr);
                log_cyc.push_back(cyc);
            end
            if (cmd == 3'b001) ref_cnt++;
            if (cmd == 3'b011) act_row = dram_addr[5:0];
            if (cmd == 3'b100) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e_w = exp_q.pop_front();
                    check("write_addr", 32'({act_row, dram_addr[9:0]}), 32'(e_w.addr));
                    check("write_data", 32'(dram_dq), 32'(e_w.data));
                    check("write_autoprecharge", 32'(dram_addr[10]), 32'd1);
                    check("write_ba", 32'(dram_ba), 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_sysrst_n", 32'(sysrst_n), 32'd0);
        check("rst_word_count", 32'(word_count), 32'h0000FFFF);
        check("rst_debug_byte", 32'(debug_byte), 32'd0);
        check("rst_cmd_nop", 32'(cmd), 32'd7);
        check("rst_dram_addr", 32'(dram_addr), 32'd0);
        check("rst_data_ready", 32'(dut.data_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("load_sysrst_n", 32'(sysrst_n), 32'd0);

        repeat (INIT_CYCLES + 40) @(posedge clk);
        #1;
        check("init_cmd_count", 32'(log_cmd.size() >= 4), 32'd1);
        if (log_cmd.size() >= 4) begin
            check("init_precharge", 32'(log_cmd[0]), 32'd2);
            check("init_precharge_a10", 32'(log_addr[0]), 32'h400);
            check("init_refresh1", 32'(log_cmd[1]), 32'd1);
            check("init_refresh2", 32'(log_cmd[2]), 32'd1);
            check("init_refresh_gap", 32'(log_cyc[2] - log_cyc[1]), 32'd8);
            check("init_load_mode", 32'(log_cmd[3]), 32'd0);
            check("init_mode_value", 32'(log_addr[3]), 32'h020);
            check("init_load_mode_gap", 32'(log_cyc[3] - log_cyc[2]), 32'd8);
        end

        send_byte(8'hAB, 1'b1);
        check("ab_data_ready", 32'(dut.data_ready), 32'd1);
        check("ab_first_flag", 32'(dut.clocked_first_byte), 32'd1);
        check("ab_rx_data", 32'(dut.rx_data), 32'hAB);
        check("ab_rx_idle", 32'(dut.rx_state), 32'd0);
        check("ab_debug_off", 32'(debug_byte), 32'd0);

        exp_q.push_back('{addr: 16'h0000, data: 16'hCDAB});
        send_byte(8'hCD, 1'b1);
        check("cd_word_count", 32'(word_count), 32'd0);
        check("cd_word_pulses", 32'(wr_pulses), 32'd1);
        check("cd_first_flag", 32'(dut.clocked_first_byte), 32'd0);
        check("cd_queue_drained", 32'(exp_q.size()), 32'd0);

        debug_mode = 1'b1;
        send_byte(8'h25, 1'b1);
        check("dbg_byte_25", 32'(debug_byte), 32'h25);
        exp_q.push_back('{addr: 16'h0001, data: 16'h9825});
        send_byte(8'h98, 1'b1);
        check("dbg_data_in_r", 32'(dut.data_in_r), 32'h9825);
        check("dbg_addr_r", 32'(dut.addr_r), 32'd1);
        check("dbg_word_count", 32'(word_count), 32'd1);
        check("dbg_word_pulses", 32'(wr_pulses), 32'd2);
        check("dbg_queue_drained", 32'(exp_q.size()), 32'd0);

        load_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst2_sysrst_n", 32'(sysrst_n), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("run_sysrst_n", 32'(sysrst_n), 32'd1);
        check("rst2_word_count", 32'(word_count), 32'h0000FFFF);
        repeat (INIT_CYCLES + 40) @(posedge clk);
        #1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("noload_word_pulses", 32'(wr_pulses), 32'd2);
        check("noload_word_count", 32'(word_count), 32'h0000FFFF);
        check("noload_first_flag", 32'(dut.clocked_first_byte), 32'd0);

        load_en = 1'b1;
        send_byte(8'h5A, 1'b1);
        check("frm_first_flag_set", 32'(dut.clocked_first_byte), 32'd1);
        send_byte(8'h3C, 1'b0);
        check("frm_data_ready", 32'(dut.data_ready), 32'd0);
        check("frm_first_flag_kept", 32'(dut.clocked_first_byte), 32'd1);
        check("frm_rx_data_kept", 32'(dut.rx_data), 32'h5A);
        exp_q.push_back('{addr: 16'h0000, data: 16'h775A});
        send_byte(8'h77, 1'b1);
        check("frm_word_count", 32'(word_count), 32'd0);
        check("frm_queue_drained", 32'(exp_q.size()), 32'd0);

        ref0 = ref_cnt;
        repeat (2000) @(posedge clk);
        #1;
`ifdef LC_AUTO_REFRESH_EN
        check("auto_refresh_count", 32'((ref_cnt - ref0) >= 5), 32'd1);
`else
        check("no_auto_refresh", 32'(ref_cnt - ref0), 32'd0);
`endif
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
